// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, LSB first, with one registered
//            borrow bit and a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_br;
    logic               r_borrow;

    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;

    // A new request is only taken when no bits are in flight.
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_cnt == c_LAST);
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_next;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            // Published result only moves on the final bit, so it stays
            // stable across the whole of the next operation.
            if (w_last) begin
                r_diff   <= w_res_next;
                r_borrow <= w_br_next;
            end
        end
    end

    assign busy       = (r_state == S_SHIFT);
    assign done       = (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed and random self-checking bench for serial_subtractor
//            at WIDTH=8 and WIDTH=16.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  diff8;
    logic        bo8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        done16;
    logic [15:0] diff16;
    logic        bo16;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start16),
        .a          (a16),
        .b          (b16),
        .busy       (busy16),
        .done       (done16),
        .diff       (diff16),
        .borrow_out (bo16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input bit detail);
        int         lat;
        int         bcnt;
        logic [8:0] gold;
        gold   = {1'b0, va} - {1'b0, vb};
        start8 = 1'b1;
        a8     = va;
        b8     = vb;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        lat    = 0;
        bcnt   = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (detail) begin
            check("latency8", lat, 8);
            check("busy_len8", bcnt, 8);
            check("busy_at_done8", busy8, 0);
        end
        check("diff8", diff8, gold[7:0]);
        check("borrow8", bo8, gold[8]);
    endtask

    task automatic run16(input logic [15:0] va, input logic [15:0] vb);
        int          lat;
        logic [16:0] gold;
        gold    = {1'b0, va} - {1'b0, vb};
        start16 = 1'b1;
        a16     = va;
        b16     = vb;
        @(negedge clk);
        start16 = 1'b0;
        a16     = 16'($urandom);
        b16     = 16'($urandom);
        lat     = 0;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency16", lat, 16);
        check("diff16", diff16, gold[15:0]);
        check("borrow16", bo16, gold[16]);
    endtask

    initial begin
        int   cnt;
        int   lat;
        bit   stable;
        logic [7:0] cap;

        // Reset state
        #12;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", bo8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operation and done pulse width
        run8(8'h5A, 8'h3C, 1'b1);
        check("diff_5A_3C", diff8, 8'h1E);
        @(negedge clk);
        check("done_falls", done8, 0);

        run8(8'h10, 8'h20, 1'b1);
        check("diff_10_20", {bo8, diff8}, 9'h1F0);
        @(negedge clk);
        run8(8'h00, 8'hFF, 1'b1);
        check("diff_00_FF", {bo8, diff8}, 9'h101);
        @(negedge clk);
        run8(8'hA5, 8'hA5, 1'b1);
        check("diff_A5_A5", {bo8, diff8}, 9'h000);
        @(negedge clk);

        // Start during SHIFT must be ignored
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        cnt = 0;
        cap = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (done8) begin
                cnt++;
                cap = diff8;
            end
            @(negedge clk);
        end
        check("ignored_done_count", cnt, 1);
        check("ignored_diff", cap, 8'h7F);
        check("ignored_borrow", bo8, 0);
        check("ignored_busy_after", busy8, 0);

        // Back-to-back with start held in the done cycle
        run8(8'h33, 8'h11, 1'b0);
        check("b2b_first", diff8, 8'h22);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        stable = 1'b1;
        while (!done8 && lat < 40) begin
            if (diff8 !== 8'h22) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("b2b_latency", lat, 8);
        check("b2b_hold", stable, 1);
        check("b2b_second", {bo8, diff8}, 9'h1FF);
        @(negedge clk);

        // Asynchronous reset mid-operation
        run8(8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_diff", diff8, 0);
        check("arst_borrow", bo8, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done8) cnt++;
        end
        check("arst_no_done", cnt, 0);
        check("arst_diff_held", diff8, 0);
        run8(8'hC3, 8'h5A, 1'b1);
        check("post_rst", {bo8, diff8}, 9'h069);
        @(negedge clk);

        // Random regression, both widths
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run8(8'($urandom), 8'($urandom), 1'b0);
        end
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run16(16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
